// File: rtl/audio_sample_queue_if.sv
// Port bundle between the CPU audio store path, the sample queue and the PWM serializer.
// The slave modport is the queue itself; the master modport is the CPU/PWM side.
interface audio_sample_queue_if #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 10
);
    logic                       wr_en;
    logic [WIDTH-1:0]           wr_data;
    logic                       enable;
    logic                       clr_flags;
    logic [WIDTH-1:0]           duty_cycle;
    logic                       sample_tick;
    logic [$clog2(DEPTH):0]     count;
    logic                       full;
    logic                       empty;
    logic                       overflow;
    logic                       underrun;

    modport slave (
        input  wr_en, wr_data, enable, clr_flags,
        output duty_cycle, sample_tick, count, full, empty, overflow, underrun
    );

    modport master (
        output wr_en, wr_data, enable, clr_flags,
        input  duty_cycle, sample_tick, count, full, empty, overflow, underrun
    );
endinterface

// File: rtl/audio_sample_queue.sv
// Sample FIFO between CPU audio stores and the PWM duty-cycle input, popped at a
// fixed rate set by SAMPLE_DIV, with sticky overflow/underrun status.
module audio_sample_queue #(
    parameter int DEPTH      = 16,
    parameter int WIDTH      = 10,
    parameter int SAMPLE_DIV = 6250
) (
    input  logic                 clock,
    input  logic                 reset,
    audio_sample_queue_if.slave  q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(SAMPLE_DIV);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DW-1:0]    div_cnt_q, div_cnt_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic             tick_q, tick_d;
    logic             overflow_q, overflow_d;
    logic             underrun_q, underrun_d;

    logic             full_s, empty_s, period_end_s, wr_acc_s, pop_s;

    // Status decode and event qualification, all judged on pre-edge count
    always_comb begin
        full_s       = (count_q == CW'(DEPTH));
        empty_s      = (count_q == {CW{1'b0}});
        period_end_s = q.enable && (div_cnt_q == DW'(SAMPLE_DIV - 1));
        wr_acc_s     = q.wr_en && !full_s;
        pop_s        = period_end_s && !empty_s;
    end

    // Next-state for pointers, count, rate counter, output sample and flags
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        div_cnt_d  = div_cnt_q;
        duty_d     = duty_q;
        tick_d     = 1'b0;
        overflow_d = overflow_q;
        underrun_d = underrun_q;

        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            duty_d   = mem_q[rd_ptr_q];
            tick_d   = 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_acc_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Disabling discards the partial period so re-enable restarts a full one
        if (!q.enable) begin
            div_cnt_d = {DW{1'b0}};
        end else if (period_end_s) begin
            div_cnt_d = {DW{1'b0}};
        end else begin
            div_cnt_d = div_cnt_q + DW'(1);
        end

        if (q.wr_en && full_s) begin
            overflow_d = 1'b1;
        end else if (q.clr_flags) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        if (period_end_s && empty_s) begin
            underrun_d = 1'b1;
        end else if (q.clr_flags) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end
    end

    // Control and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {CW{1'b0}};
            div_cnt_q  <= {DW{1'b0}};
            duty_q     <= {WIDTH{1'b0}};
            tick_q     <= 1'b0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            div_cnt_q  <= div_cnt_d;
            duty_q     <= duty_d;
            tick_q     <= tick_d;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
        end
    end

    // Sample storage; contents deliberately survive reset
    always_ff @(posedge clock) begin
        if (wr_acc_s) begin
            mem_q[wr_ptr_q] <= q.wr_data;
        end
    end

    assign q.duty_cycle  = duty_q;
    assign q.sample_tick = tick_q;
    assign q.count       = count_q;
    assign q.full        = full_s;
    assign q.empty       = empty_s;
    assign q.overflow    = overflow_q;
    assign q.underrun    = underrun_q;
endmodule

// File: tb/tb_audio_sample_queue.sv
// Directed bench for audio_sample_queue with DEPTH=4, SAMPLE_DIV=4.
module tb_audio_sample_queue;
    logic clock;
    logic reset;
    int   checks;
    int   passed;

    audio_sample_queue_if #(.DEPTH(4), .WIDTH(10)) q_if ();

    audio_sample_queue #(.DEPTH(4), .WIDTH(10), .SAMPLE_DIV(4)) dut (
        .clock (clock),
        .reset (reset),
        .q     (q_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wr(input logic [9:0] v);
        q_if.wr_en   = 1'b1;
        q_if.wr_data = v;
        step(1);
        q_if.wr_en   = 1'b0;
    endtask

    task automatic test_reset;
        reset          = 1'b0;
        q_if.wr_en     = 1'b0;
        q_if.wr_data   = 10'd0;
        q_if.enable    = 1'b0;
        q_if.clr_flags = 1'b0;
        #3;
        checks++; if (q_if.count !== 3'd0) $display("FAIL rst_count got=%0d exp=0", q_if.count); else passed++;
        checks++; if (q_if.empty !== 1'b1 || q_if.full !== 1'b0) $display("FAIL rst_empty_full got=%b%b exp=10", q_if.empty, q_if.full); else passed++;
        checks++; if (q_if.duty_cycle !== 10'd0 || q_if.sample_tick !== 1'b0) $display("FAIL rst_duty got=%0d/%b exp=0/0", q_if.duty_cycle, q_if.sample_tick); else passed++;
        checks++; if (q_if.overflow !== 1'b0 || q_if.underrun !== 1'b0) $display("FAIL rst_flags got=%b%b exp=00", q_if.overflow, q_if.underrun); else passed++;
        step(2);
        reset = 1'b1;
        step(1);
    endtask

    task automatic test_ordered_playback;
        wr(10'd100); wr(10'd200); wr(10'd300);
        checks++; if (q_if.count !== 3'd3) $display("FAIL play_count3 got=%0d exp=3", q_if.count); else passed++;
        q_if.enable = 1'b1;
        step(3);
        checks++; if (q_if.duty_cycle !== 10'd0 || q_if.sample_tick !== 1'b0) $display("FAIL play_early got=%0d/%b exp=0/0", q_if.duty_cycle, q_if.sample_tick); else passed++;
        step(1);
        checks++; if (q_if.duty_cycle !== 10'd100 || q_if.sample_tick !== 1'b1 || q_if.count !== 3'd2) $display("FAIL play_pop1 got=%0d/%b/%0d exp=100/1/2", q_if.duty_cycle, q_if.sample_tick, q_if.count); else passed++;
        step(1);
        checks++; if (q_if.sample_tick !== 1'b0 || q_if.duty_cycle !== 10'd100) $display("FAIL play_tick_width got=%b/%0d exp=0/100", q_if.sample_tick, q_if.duty_cycle); else passed++;
        step(3);
        checks++; if (q_if.duty_cycle !== 10'd200 || q_if.sample_tick !== 1'b1 || q_if.count !== 3'd1) $display("FAIL play_pop2 got=%0d/%b/%0d exp=200/1/1", q_if.duty_cycle, q_if.sample_tick, q_if.count); else passed++;
        step(4);
        checks++; if (q_if.duty_cycle !== 10'd300 || q_if.count !== 3'd0 || q_if.empty !== 1'b1) $display("FAIL play_pop3 got=%0d/%0d/%b exp=300/0/1", q_if.duty_cycle, q_if.count, q_if.empty); else passed++;
        q_if.enable = 1'b0;
        checks++; if (q_if.underrun !== 1'b0) $display("FAIL play_no_underrun got=%b exp=0", q_if.underrun); else passed++;
    endtask

    task automatic test_overflow;
        q_if.wr_en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            q_if.wr_data = 10'(i);
            step(1);
        end
        q_if.wr_en = 1'b0;
        checks++; if (q_if.count !== 3'd4 || q_if.full !== 1'b1 || q_if.overflow !== 1'b1) $display("FAIL ovf_state got=%0d/%b/%b exp=4/1/1", q_if.count, q_if.full, q_if.overflow); else passed++;
        q_if.enable = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step(4);
            checks++; if (q_if.duty_cycle !== 10'(i) || q_if.sample_tick !== 1'b1) $display("FAIL ovf_play%0d got=%0d/%b exp=%0d/1", i, q_if.duty_cycle, q_if.sample_tick, i); else passed++;
        end
        q_if.enable = 1'b0;
        checks++; if (q_if.count !== 3'd0 || q_if.empty !== 1'b1) $display("FAIL ovf_drained got=%0d/%b exp=0/1", q_if.count, q_if.empty); else passed++;
        q_if.clr_flags = 1'b1;
        step(1);
        q_if.clr_flags = 1'b0;
        checks++; if (q_if.overflow !== 1'b0) $display("FAIL ovf_clear got=%b exp=0", q_if.overflow); else passed++;
    endtask

    task automatic test_underrun_hold;
        wr(10'd512);
        q_if.enable = 1'b1;
        step(4);
        checks++; if (q_if.duty_cycle !== 10'd512 || q_if.sample_tick !== 1'b1) $display("FAIL und_pop got=%0d/%b exp=512/1", q_if.duty_cycle, q_if.sample_tick); else passed++;
        step(3);
        checks++; if (q_if.underrun !== 1'b0) $display("FAIL und_early got=%b exp=0", q_if.underrun); else passed++;
        step(1);
        checks++; if (q_if.underrun !== 1'b1 || q_if.duty_cycle !== 10'd512 || q_if.sample_tick !== 1'b0) $display("FAIL und_hold got=%b/%0d/%b exp=1/512/0", q_if.underrun, q_if.duty_cycle, q_if.sample_tick); else passed++;
        q_if.clr_flags = 1'b1;
        step(1);
        q_if.clr_flags = 1'b0;
        q_if.enable    = 1'b0;
        checks++; if (q_if.underrun !== 1'b0) $display("FAIL und_clear got=%b exp=0", q_if.underrun); else passed++;
    endtask

    task automatic test_simultaneous;
        wr(10'd10); wr(10'd11); wr(10'd12); wr(10'd13);
        q_if.enable = 1'b1;
        step(3);
        q_if.wr_en   = 1'b1;
        q_if.wr_data = 10'd99;
        step(1);
        q_if.wr_en   = 1'b0;
        checks++; if (q_if.count !== 3'd3 || q_if.overflow !== 1'b1 || q_if.duty_cycle !== 10'd10) $display("FAIL sim_full_pop got=%0d/%b/%0d exp=3/1/10", q_if.count, q_if.overflow, q_if.duty_cycle); else passed++;
        step(12);
        checks++; if (q_if.duty_cycle !== 10'd13 || q_if.count !== 3'd0) $display("FAIL sim_dropped got=%0d/%0d exp=13/0", q_if.duty_cycle, q_if.count); else passed++;
        step(3);
        q_if.wr_en   = 1'b1;
        q_if.wr_data = 10'd77;
        step(1);
        q_if.wr_en   = 1'b0;
        checks++; if (q_if.underrun !== 1'b1 || q_if.count !== 3'd1 || q_if.sample_tick !== 1'b0 || q_if.duty_cycle !== 10'd13) $display("FAIL sim_empty_wr got=%b/%0d/%b/%0d exp=1/1/0/13", q_if.underrun, q_if.count, q_if.sample_tick, q_if.duty_cycle); else passed++;
        step(4);
        checks++; if (q_if.duty_cycle !== 10'd77 || q_if.count !== 3'd0) $display("FAIL sim_wr_stored got=%0d/%0d exp=77/0", q_if.duty_cycle, q_if.count); else passed++;
        q_if.enable = 1'b0;
        wr(10'd20); wr(10'd21); wr(10'd22); wr(10'd23);
        q_if.wr_en     = 1'b1;
        q_if.wr_data   = 10'd88;
        q_if.clr_flags = 1'b1;
        step(1);
        q_if.wr_en     = 1'b0;
        q_if.clr_flags = 1'b0;
        checks++; if (q_if.overflow !== 1'b1 || q_if.underrun !== 1'b0 || q_if.count !== 3'd4) $display("FAIL sim_clr_set got=%b/%b/%0d exp=1/0/4", q_if.overflow, q_if.underrun, q_if.count); else passed++;
    endtask

    task automatic test_enable_gating;
        q_if.enable = 1'b1;
        step(8);
        checks++; if (q_if.duty_cycle !== 10'd21 || q_if.count !== 3'd2) $display("FAIL gate_setup got=%0d/%0d exp=21/2", q_if.duty_cycle, q_if.count); else passed++;
        step(2);
        q_if.enable = 1'b0;
        step(4);
        checks++; if (q_if.count !== 3'd2 || q_if.duty_cycle !== 10'd21 || q_if.sample_tick !== 1'b0) $display("FAIL gate_hold got=%0d/%0d/%b exp=2/21/0", q_if.count, q_if.duty_cycle, q_if.sample_tick); else passed++;
        q_if.enable = 1'b1;
        step(3);
        checks++; if (q_if.count !== 3'd2 || q_if.duty_cycle !== 10'd21) $display("FAIL gate_restart_early got=%0d/%0d exp=2/21", q_if.count, q_if.duty_cycle); else passed++;
        step(1);
        checks++; if (q_if.duty_cycle !== 10'd22 || q_if.sample_tick !== 1'b1 || q_if.count !== 3'd1) $display("FAIL gate_restart_pop got=%0d/%b/%0d exp=22/1/1", q_if.duty_cycle, q_if.sample_tick, q_if.count); else passed++;
        q_if.enable = 1'b0;
    endtask

    task automatic test_reset_midrun;
        wr(10'd30); wr(10'd31);
        checks++; if (q_if.count !== 3'd3 || q_if.overflow !== 1'b1) $display("FAIL mrst_pre got=%0d/%b exp=3/1", q_if.count, q_if.overflow); else passed++;
        #2 reset = 1'b0;
        #2;
        checks++; if (q_if.count !== 3'd0 || q_if.empty !== 1'b1 || q_if.duty_cycle !== 10'd0) $display("FAIL mrst_async got=%0d/%b/%0d exp=0/1/0", q_if.count, q_if.empty, q_if.duty_cycle); else passed++;
        checks++; if (q_if.overflow !== 1'b0 || q_if.underrun !== 1'b0) $display("FAIL mrst_flags got=%b%b exp=00", q_if.overflow, q_if.underrun); else passed++;
        #2 reset = 1'b1;
        q_if.enable = 1'b1;
        step(3);
        checks++; if (q_if.underrun !== 1'b0) $display("FAIL mrst_und_early got=%b exp=0", q_if.underrun); else passed++;
        step(1);
        checks++; if (q_if.underrun !== 1'b1 || q_if.sample_tick !== 1'b0 || q_if.duty_cycle !== 10'd0) $display("FAIL mrst_underrun got=%b/%b/%0d exp=1/0/0", q_if.underrun, q_if.sample_tick, q_if.duty_cycle); else passed++;
        q_if.enable = 1'b0;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset;
        test_ordered_playback;
        test_overflow;
        test_underrun_hold;
        test_simultaneous;
        test_enable_gating;
        test_reset_midrun;
        step(2);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/audio_sample_queue.md
# audio_sample_queue

Buffers audio samples written by the processor through the memory-mapped audio port and releases them to the PWM serializer at a fixed sample rate. It sits between the CPU store path (store to address 4098) and the `PWMSerializer` duty-cycle input, replacing the single duty-cycle register. Software can therefore write bursts of samples, and playback timing no longer depends on instruction timing. Status outputs let software poll fill level and detect overflow and underrun.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `WIDTH`, 10: sample width in bits; matches the PWM duty-cycle width.
- `SAMPLE_DIV`, 6250: clock cycles per output sample (50 MHz / 8 kHz); at least 2.
- `clock` input, 1 bit: single system clock (50 MHz domain); all logic is on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low; clears all state.
- `wr_en` input, 1 bit: sample write strobe (`mwe` and address 4098); one sample per high cycle.
- `wr_data` input, `WIDTH` bits: sample value, taken from store data [9:0].
- `enable` input, 1 bit: playback enable; gates the rate counter and pops.
- `clr_flags` input, 1 bit: clears the sticky `overflow` and `underrun` flags.
- `duty_cycle` output, `WIDTH` bits: current sample driven to `PWMSerializer`.
- `sample_tick` output, 1 bit: one-cycle pulse in the cycle `duty_cycle` takes a new popped value.
- `count` output, log2(`DEPTH`)+1 bits: number of entries in the FIFO.
- `full` output, 1 bit: high when `count == DEPTH`.
- `empty` output, 1 bit: high when `count == 0`.
- `overflow` output, 1 bit: sticky; a write was dropped because the FIFO was full.
- `underrun` output, 1 bit: sticky; a sample period elapsed while the FIFO was empty.

## Operation
- **Storage.** Circular buffer with `wr_ptr` and `rd_ptr`, each log2(`DEPTH`) bits, wrapping modulo `DEPTH`. `count` is a separate registered counter.
- **Write.** On `wr_en` with `full` low: store `wr_data` at `wr_ptr` and increment `wr_ptr`.
  - On `wr_en` with `full` high: drop the data, leave the pointer unchanged, set `overflow`.
  - Writes are accepted regardless of `enable`.
- **Rate counter.** `div_cnt` counts from 0 to `SAMPLE_DIV`-1 while `enable` is high.
  - The terminal count (`div_cnt == SAMPLE_DIV`-1) wraps the counter to 0 and generates an internal `period_end`.
  - While `enable` is low, `div_cnt` is held at 0 and no `period_end` occurs.
- **Pop.** On `period_end` with `empty` low: load `duty_cycle` from the entry at `rd_ptr`, increment `rd_ptr`, and pulse `sample_tick`.
  - On `period_end` with `empty` high: `duty_cycle` holds its last value, `sample_tick` stays low, and `underrun` is set.
- **Simultaneous write and pop.** Both occur and `count` is unchanged.
  - `full` and `empty` are judged on the pre-edge `count`.
  - A write while full is dropped even if a pop happens in the same cycle.
  - A pop while empty underruns even if a write happens in the same cycle; that write is stored.
- **Flags.** `clr_flags` clears `overflow` and `underrun`. If a set condition occurs in the same cycle as `clr_flags`, the set wins.
- **Enable deassert mid-period.** The partial period is discarded and `duty_cycle` holds. After re-enable, the next pop occurs `SAMPLE_DIV` cycles later.
- **Reset (asynchronous, `reset` low).** Clears pointers, `count`, `div_cnt`, `duty_cycle`, `sample_tick`, `overflow` and `underrun` to 0. Consequently `empty`=1 and `full`=0.
  - Storage contents are not cleared.
  - Reset during an active period aborts it with no pop.

## Timing
- All outputs are registered except `full` and `empty`, which are decoded combinationally from registered `count`.
- **Write to `count`.** `count` reflects a write at the edge that samples `wr_en`, so it is visible in the next cycle.
- **Enable to first pop.** With the FIFO non-empty and `enable` rising before edge 0, the first `sample_tick` and new `duty_cycle` appear after edge `SAMPLE_DIV`-1. The pops then repeat every `SAMPLE_DIV` cycles exactly.
- **`sample_tick` width.** Exactly one cycle, coincident with the first cycle of the new `duty_cycle` value.
- **Write to output latency.** Minimum 1 cycle, when the write lands in an empty FIFO one cycle before `period_end`.
- **Throughput.** One write per cycle is accepted; one pop per `SAMPLE_DIV` cycles.

## Test plan
Bench parameters: `DEPTH`=4, `SAMPLE_DIV`=4.
- **Reset.** Drive `reset` low mid-run with `count`=3 → `count`=0, `empty`=1, `duty_cycle`=0 and flags 0 asynchronously. The next pop attempt sets `underrun`.
- **Ordered playback.** Write 100, 200, 300 with `enable`=1 → `duty_cycle` steps 100→200→300 at 4-cycle intervals, with one `sample_tick` per step. `count` goes 3→2→1→0 and `empty`=1 after the third pop.
- **Overflow.** Write 5 samples (1–5) back to back with `enable`=0 → `count`=4, `full`=1, `overflow`=1. Enabling then plays 1, 2, 3, 4 only, and `ptr` wrap is exercised.
- **Underrun and hold.** Write one sample (512) and enable → `duty_cycle`=512. At the next period end `underrun`=1, `duty_cycle` stays 512 and `sample_tick` stays 0. `clr_flags` clears the flag.
- **Simultaneous events.**
  - With `count`=4, assert `wr_en` on the `period_end` cycle → write dropped, `overflow`=1, `count`=3.
  - With `count`=0, assert `wr_en` on `period_end` → `underrun`=1, `count`=1.
  - Assert `clr_flags` together with an overflowing write → `overflow` stays 1.
- **Enable gating.** Drop `enable` 2 cycles into a period with `count`=2 → no pop. Re-enable → first pop exactly 4 cycles later.
